// File: rtl/al_reg_arbiter.sv
// al_reg_arbiter: two-requester round-robin front end for a 4-register AXI4-Lite
// slave. One access is in flight at a time; misaligned addresses are rejected
// locally without touching the bus.

module al_reg_arbiter #(
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                              ACLK,
  input  logic                              ARESET,

  input  logic                              r0_req,
  input  logic                              r0_we,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     r0_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     r0_wdata,
  output logic                              r0_gnt,
  output logic                              r0_done,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     r0_rdata,
  output logic                              r0_err,

  input  logic                              r1_req,
  input  logic                              r1_we,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     r1_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     r1_wdata,
  output logic                              r1_gnt,
  output logic                              r1_done,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     r1_rdata,
  output logic                              r1_err,

  output logic [C_S_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RRESP, ERR} state_t;

  state_t                          state_q, state_d;
  logic                            last_q, last_d;     // 1 = r1 was granted last
  logic                            owner_q, owner_d;   // requester being served
  logic [C_S_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [C_S_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                            aw_valid_q, aw_valid_d;
  logic                            w_valid_q, w_valid_d;
  logic                            ar_valid_q, ar_valid_d;
  logic [1:0]                      gnt_q, gnt_d;
  logic [1:0]                      done_q, done_d;
  logic [1:0]                      err_q, err_d;
  logic [C_S_AXI_DATA_WIDTH-1:0]   rdata0_q, rdata0_d;
  logic [C_S_AXI_DATA_WIDTH-1:0]   rdata1_q, rdata1_d;

  logic                            pick;
  logic                            pick_we;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   pick_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0]   pick_wdata;
  logic [1:0]                      owner_mask;
  logic                            unused_resp;

  // Round-robin choice: a lone requester wins, otherwise whoever was not served last.
  always_comb begin
    pick = r1_req;
    if (r0_req && r1_req) begin
      pick = ~last_q;
    end
  end

  assign pick_we    = pick ? r1_we    : r0_we;
  assign pick_addr  = pick ? r1_addr  : r0_addr;
  assign pick_wdata = pick ? r1_wdata : r0_wdata;
  assign owner_mask = owner_q ? 2'b10 : 2'b01;

  // Next-state logic; requests are not sampled while a done pulse is out, which
  // spaces back-to-back accesses by one idle cycle.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    ar_valid_d = ar_valid_q;
    gnt_d      = 2'b00;
    done_d     = 2'b00;
    err_d      = err_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;

    case (state_q)
      IDLE: begin
        if ((done_q == 2'b00) && (r0_req || r1_req)) begin
          last_d  = pick;
          owner_d = pick;
          addr_d  = pick_addr;
          wdata_d = pick_wdata;
          gnt_d   = pick ? 2'b10 : 2'b01;
          if (pick_addr[1:0] != 2'b00) begin
            state_d = ERR;
          end else if (pick_we) begin
            state_d    = WADDR;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
          end else begin
            state_d    = RADDR;
            ar_valid_d = 1'b1;
          end
        end
      end

      WADDR: begin
        if (aw_valid_q && M_AXI_AWREADY) aw_valid_d = 1'b0;
        if (w_valid_q && M_AXI_WREADY)   w_valid_d  = 1'b0;
        if ((!aw_valid_q || M_AXI_AWREADY) && (!w_valid_q || M_AXI_WREADY)) begin
          state_d = WRESP;
        end
      end

      WRESP: begin
        if (M_AXI_BVALID) begin
          state_d = IDLE;
          done_d  = owner_mask;
          if (owner_q) err_d[1] = M_AXI_BRESP[1];
          else         err_d[0] = M_AXI_BRESP[1];
        end
      end

      RADDR: begin
        if (M_AXI_ARREADY) begin
          ar_valid_d = 1'b0;
          state_d    = RRESP;
        end
      end

      RRESP: begin
        if (M_AXI_RVALID) begin
          state_d = IDLE;
          done_d  = owner_mask;
          if (owner_q) begin
            err_d[1] = M_AXI_RRESP[1];
            rdata1_d = M_AXI_RDATA;
          end else begin
            err_d[0] = M_AXI_RRESP[1];
            rdata0_d = M_AXI_RDATA;
          end
        end
      end

      ERR: begin
        state_d = IDLE;
        done_d  = owner_mask;
        if (owner_q) err_d[1] = 1'b1;
        else         err_d[0] = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any access without a done pulse.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      gnt_q      <= 2'b00;
      done_q     <= 2'b00;
      err_q      <= 2'b00;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      ar_valid_q <= ar_valid_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign r0_gnt   = gnt_q[0];
  assign r1_gnt   = gnt_q[1];
  assign r0_done  = done_q[0];
  assign r1_done  = done_q[1];
  assign r0_err   = err_q[0];
  assign r1_err   = err_q[1];
  assign r0_rdata = rdata0_q;
  assign r1_rdata = rdata1_q;

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = aw_valid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = w_valid_q;
  assign M_AXI_BREADY  = (state_q == WRESP);
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = ar_valid_q;
  assign M_AXI_RREADY  = (state_q == RRESP);

  // Only the SLVERR/DECERR bit of each response matters here.
  assign unused_resp = ^{M_AXI_BRESP[0], M_AXI_RRESP[0]};

endmodule
